// File: rtl/except_unit_pkg.sv
// Shared definitions for the memory-stage exception arbiter: type codes,
// CP0 register numbers, FSM states and the fixed-priority winner selector.
package except_unit_pkg;

  localparam logic [31:0] ZERO_WORD   = 32'h0000_0000;

  localparam logic [31:0] EXC_INT     = 32'h0000_0001;
  localparam logic [31:0] EXC_ADEL    = 32'h0000_0004;
  localparam logic [31:0] EXC_ADES    = 32'h0000_0005;
  localparam logic [31:0] EXC_SYSCALL = 32'h0000_0008;
  localparam logic [31:0] EXC_BREAK   = 32'h0000_0009;
  localparam logic [31:0] EXC_RI      = 32'h0000_000a;
  localparam logic [31:0] EXC_OV      = 32'h0000_000c;
  localparam logic [31:0] EXC_TRAP    = 32'h0000_000d;
  localparam logic [31:0] EXC_ERET    = 32'h0000_000e;

  localparam logic [4:0] CP0_REG_STATUS = 5'd12;
  localparam logic [4:0] CP0_REG_CAUSE  = 5'd13;
  localparam logic [4:0] CP0_REG_EPC    = 5'd14;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_FLUSH = 1'b1
  } exc_state_e;

  typedef struct packed {
    logic [31:0] excepttype;
    logic [31:0] bad_addr;
  } exc_sel_t;

  // Highest priority first; a result with excepttype == ZERO_WORD means no winner.
  function automatic exc_sel_t pick_exception(
    input logic        int_take,
    input logic        adel_if,
    input logic        ri,
    input logic        ov,
    input logic        syscall,
    input logic        brk,
    input logic        adel_d,
    input logic        ades_d,
    input logic        eret,
    input logic [31:0] pc,
    input logic [31:0] addr
  );
    exc_sel_t sel;
    sel.excepttype = ZERO_WORD;
    sel.bad_addr   = ZERO_WORD;
    if (int_take)     sel.excepttype = EXC_INT;
    else if (adel_if) begin
      sel.excepttype = EXC_ADEL;
      sel.bad_addr   = pc;
    end
    else if (ri)      sel.excepttype = EXC_RI;
    else if (ov)      sel.excepttype = EXC_OV;
    else if (syscall) sel.excepttype = EXC_SYSCALL;
    else if (brk)     sel.excepttype = EXC_BREAK;
    else if (adel_d) begin
      sel.excepttype = EXC_ADEL;
      sel.bad_addr   = addr;
    end
    else if (ades_d) begin
      sel.excepttype = EXC_ADES;
      sel.bad_addr   = addr;
    end
    else if (eret)    sel.excepttype = EXC_ERET;
    return sel;
  endfunction

endpackage

// File: rtl/except_unit_cp0_fwd.sv
// Combinational merge of a same-cycle WB MTC0 write into the CP0 Status,
// Cause and EPC values; also usable by the MFC0 bypass path.
module except_unit_cp0_fwd
  import except_unit_pkg::*;
(
  input  logic [31:0] cp0_status_i,
  input  logic [31:0] cp0_cause_i,
  input  logic [31:0] cp0_epc_i,
  input  logic        wb_cp0_we_i,
  input  logic [4:0]  wb_cp0_waddr_i,
  input  logic [31:0] wb_cp0_data_i,
  output logic [31:0] eff_status_o,
  output logic [31:0] eff_cause_o,
  output logic [31:0] eff_epc_o
);

  always_comb begin
    eff_status_o = cp0_status_i;
    eff_cause_o  = cp0_cause_i;
    eff_epc_o    = cp0_epc_i;
    if (wb_cp0_we_i) begin
      unique case (wb_cp0_waddr_i)
        // Only IM, EXL and IE are software-writable in Status.
        CP0_REG_STATUS: eff_status_o = {cp0_status_i[31:16], wb_cp0_data_i[15:8],
                                        cp0_status_i[7:2], wb_cp0_data_i[1:0]};
        CP0_REG_CAUSE:  eff_cause_o  = {cp0_cause_i[31:10], wb_cp0_data_i[9:8],
                                        cp0_cause_i[7:0]};
        CP0_REG_EPC:    eff_epc_o    = wb_cp0_data_i;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/except_unit.sv
// Memory-stage exception arbiter: picks one exception per accepted MEM
// instruction, pulses it to CP0 for one cycle and flushes/redirects the pipe.
module except_unit
  import except_unit_pkg::*;
#(
  parameter logic [31:0] EXC_VECTOR   = 32'hBFC0_0380,
  parameter int unsigned FLUSH_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_valid_i,
  input  logic        mem_stall_i,
  input  logic [31:0] mem_pc_i,
  input  logic        mem_delayslot_i,
  input  logic [31:0] mem_addr_i,
  input  logic        adel_if_i,
  input  logic        ri_i,
  input  logic        ov_i,
  input  logic        syscall_i,
  input  logic        break_i,
  input  logic        adel_d_i,
  input  logic        ades_d_i,
  input  logic        eret_i,
  input  logic [31:0] cp0_status_i,
  input  logic [31:0] cp0_cause_i,
  input  logic [31:0] cp0_epc_i,
  input  logic        wb_cp0_we_i,
  input  logic [4:0]  wb_cp0_waddr_i,
  input  logic [31:0] wb_cp0_data_i,
  output logic [31:0] excepttype_o,
  output logic [31:0] current_inst_addr_o,
  output logic        is_in_delayslot_o,
  output logic [31:0] bad_addr_o,
  output logic        flush_o,
  output logic [31:0] newpc_o,
  output exc_state_e  state_o
);

  localparam logic [3:0] FLUSH_INIT = 4'(FLUSH_CYCLES);

  logic [31:0] eff_status, eff_cause, eff_epc;
  logic        int_cond, accept, fire;
  exc_sel_t    sel;

  exc_state_e  state_q, state_d;
  logic [3:0]  flush_cnt_q, flush_cnt_d;
  logic        int_pending_q, int_pending_d;
  logic        flush_q, flush_d;
  logic [31:0] newpc_q, newpc_d;
  logic [31:0] excepttype_q, excepttype_d;
  logic [31:0] inst_addr_q, inst_addr_d;
  logic        delayslot_q, delayslot_d;
  logic [31:0] bad_addr_q, bad_addr_d;

  except_unit_cp0_fwd u_cp0_fwd (
    .cp0_status_i   (cp0_status_i),
    .cp0_cause_i    (cp0_cause_i),
    .cp0_epc_i      (cp0_epc_i),
    .wb_cp0_we_i    (wb_cp0_we_i),
    .wb_cp0_waddr_i (wb_cp0_waddr_i),
    .wb_cp0_data_i  (wb_cp0_data_i),
    .eff_status_o   (eff_status),
    .eff_cause_o    (eff_cause),
    .eff_epc_o      (eff_epc)
  );

  assign int_cond = eff_status[0] & ~eff_status[1] & (|(eff_cause[15:8] & eff_status[15:8]));
  assign accept   = (state_q == ST_IDLE) & mem_valid_i & ~mem_stall_i;
  assign sel      = pick_exception(accept & (int_pending_q | int_cond), adel_if_i, ri_i, ov_i,
                                   syscall_i, break_i, adel_d_i, ades_d_i, eret_i,
                                   mem_pc_i, mem_addr_i);
  assign fire     = accept & (sel.excepttype != ZERO_WORD);

  always_comb begin
    state_d      = state_q;
    flush_cnt_d  = flush_cnt_q;
    flush_d      = flush_q;
    newpc_d      = newpc_q;
    excepttype_d = ZERO_WORD;
    inst_addr_d  = ZERO_WORD;
    delayslot_d  = 1'b0;
    bad_addr_d   = ZERO_WORD;

    // Pending latches the interrupt while MEM holds bubbles; only armed in IDLE.
    int_pending_d = int_pending_q;
    if (fire || !int_cond)         int_pending_d = 1'b0;
    else if (state_q == ST_IDLE)   int_pending_d = 1'b1;

    unique case (state_q)
      ST_IDLE: begin
        if (fire) begin
          state_d      = ST_FLUSH;
          flush_cnt_d  = FLUSH_INIT;
          flush_d      = 1'b1;
          newpc_d      = (sel.excepttype == EXC_ERET) ? eff_epc : EXC_VECTOR;
          excepttype_d = sel.excepttype;
          inst_addr_d  = mem_pc_i;
          delayslot_d  = mem_delayslot_i;
          bad_addr_d   = sel.bad_addr;
        end
      end
      ST_FLUSH: begin
        if (flush_cnt_q == 4'd1) begin
          state_d     = ST_IDLE;
          flush_cnt_d = 4'd0;
          flush_d     = 1'b0;
          newpc_d     = ZERO_WORD;
        end else begin
          flush_cnt_d = flush_cnt_q - 4'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= ST_IDLE;
      flush_cnt_q   <= 4'd0;
      int_pending_q <= 1'b0;
      flush_q       <= 1'b0;
      newpc_q       <= ZERO_WORD;
      excepttype_q  <= ZERO_WORD;
      inst_addr_q   <= ZERO_WORD;
      delayslot_q   <= 1'b0;
      bad_addr_q    <= ZERO_WORD;
    end else begin
      state_q       <= state_d;
      flush_cnt_q   <= flush_cnt_d;
      int_pending_q <= int_pending_d;
      flush_q       <= flush_d;
      newpc_q       <= newpc_d;
      excepttype_q  <= excepttype_d;
      inst_addr_q   <= inst_addr_d;
      delayslot_q   <= delayslot_d;
      bad_addr_q    <= bad_addr_d;
    end
  end

  assign excepttype_o        = excepttype_q;
  assign current_inst_addr_o = inst_addr_q;
  assign is_in_delayslot_o   = delayslot_q;
  assign bad_addr_o          = bad_addr_q;
  assign flush_o             = flush_q;
  assign newpc_o             = newpc_q;
  assign state_o             = state_q;

endmodule

// File: tb/tb_except_unit.sv
// Directed bench for except_unit: stimulus pushes expected CP0 pulses into a
// queue, a negedge monitor pops/compares them and checks flush length/newpc.
module tb_except_unit;
  import except_unit_pkg::*;

  localparam logic [31:0] VEC = 32'hBFC0_0380;
  localparam int          FC  = 2;

  typedef struct packed {
    logic [31:0] typ;
    logic [31:0] pc;
    logic        ds;
    logic [31:0] bad;
    logic [31:0] newpc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        mem_valid_i, mem_stall_i, mem_delayslot_i;
  logic [31:0] mem_pc_i, mem_addr_i;
  logic        adel_if_i, ri_i, ov_i, syscall_i, break_i, adel_d_i, ades_d_i, eret_i;
  logic [31:0] cp0_status_i, cp0_cause_i, cp0_epc_i;
  logic        wb_cp0_we_i;
  logic [4:0]  wb_cp0_waddr_i;
  logic [31:0] wb_cp0_data_i;
  logic [31:0] excepttype_o, current_inst_addr_o, bad_addr_o, newpc_o;
  logic        is_in_delayslot_o, flush_o;
  exc_state_e  state_o;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   flush_len = 0;
  logic [31:0] flush_pc;

  except_unit #(.EXC_VECTOR(VEC), .FLUSH_CYCLES(FC)) dut (
    .clk(clk), .rst(rst),
    .mem_valid_i(mem_valid_i), .mem_stall_i(mem_stall_i), .mem_pc_i(mem_pc_i),
    .mem_delayslot_i(mem_delayslot_i), .mem_addr_i(mem_addr_i),
    .adel_if_i(adel_if_i), .ri_i(ri_i), .ov_i(ov_i), .syscall_i(syscall_i),
    .break_i(break_i), .adel_d_i(adel_d_i), .ades_d_i(ades_d_i), .eret_i(eret_i),
    .cp0_status_i(cp0_status_i), .cp0_cause_i(cp0_cause_i), .cp0_epc_i(cp0_epc_i),
    .wb_cp0_we_i(wb_cp0_we_i), .wb_cp0_waddr_i(wb_cp0_waddr_i), .wb_cp0_data_i(wb_cp0_data_i),
    .excepttype_o(excepttype_o), .current_inst_addr_o(current_inst_addr_o),
    .is_in_delayslot_o(is_in_delayslot_o), .bad_addr_o(bad_addr_o),
    .flush_o(flush_o), .newpc_o(newpc_o), .state_o(state_o)
  );

  // Clock and reset
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Driver tasks
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    mem_valid_i = 0; mem_stall_i = 0; mem_delayslot_i = 0;
    mem_pc_i = 0; mem_addr_i = 0;
    adel_if_i = 0; ri_i = 0; ov_i = 0; syscall_i = 0; break_i = 0;
    adel_d_i = 0; ades_d_i = 0; eret_i = 0;
    cp0_status_i = 0; cp0_cause_i = 0; cp0_epc_i = 0;
    wb_cp0_we_i = 0; wb_cp0_waddr_i = 0; wb_cp0_data_i = 0;
  endtask

  // Inputs are set by the caller; this presents them for one cycle.
  task automatic issue(input exp_t e);
    mem_valid_i = 1;
    exp_q.push_back(e);
    step(1);
    clear_inputs();
  endtask

  task automatic expect_quiet(input string name, input int n);
    for (int i = 0; i < n; i++) begin
      step(1);
      check({name, "_type"}, excepttype_o, 32'h0);
      check({name, "_flush"}, {31'b0, flush_o}, 32'h0);
    end
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    if (!rst) begin
      flush_len = 0;
    end else begin
      if (excepttype_o != 32'h0) begin
        if (exp_q.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL unexpected_event: got type %h pc %h expected none", excepttype_o, current_inst_addr_o);
        end else begin
          mon_e = exp_q.pop_front();
          check("type", excepttype_o, mon_e.typ);
          check("pc", current_inst_addr_o, mon_e.pc);
          check("delayslot", {31'b0, is_in_delayslot_o}, {31'b0, mon_e.ds});
          check("bad_addr", bad_addr_o, mon_e.bad);
          check("flush_on_event", {31'b0, flush_o}, 32'h1);
          check("newpc", newpc_o, mon_e.newpc);
        end
      end
      if (flush_o) begin
        if (flush_len == 0) flush_pc = newpc_o;
        else check("newpc_stable", newpc_o, flush_pc);
        flush_len++;
      end else if (flush_len != 0) begin
        check("flush_len", flush_len, FC);
        check("newpc_after_flush", newpc_o, 32'h0);
        flush_len = 0;
      end
    end
  end

  initial begin
    clear_inputs();
    step(3);
    check("rst_type", excepttype_o, 32'h0);
    check("rst_pc", current_inst_addr_o, 32'h0);
    check("rst_ds", {31'b0, is_in_delayslot_o}, 32'h0);
    check("rst_bad", bad_addr_o, 32'h0);
    check("rst_flush", {31'b0, flush_o}, 32'h0);
    check("rst_newpc", newpc_o, 32'h0);
    check("rst_state", {31'b0, state_o}, {31'b0, ST_IDLE});
    rst = 1;
    step(2);

    // Overflow, then earliest legal next acceptance at N+FC+1
    mem_pc_i = 32'h8000_1000; ov_i = 1;
    issue('{32'hc, 32'h8000_1000, 1'b0, 32'h0, VEC});
    step(FC);
    mem_pc_i = 32'h8000_1010; syscall_i = 1;
    issue('{32'h8, 32'h8000_1010, 1'b0, 32'h0, VEC});
    step(4);

    // RI beats AdES; bad address cleared
    mem_pc_i = 32'h8000_1004; mem_addr_i = 32'h13; ri_i = 1; ades_d_i = 1;
    issue('{32'ha, 32'h8000_1004, 1'b0, 32'h0, VEC});
    step(4);

    // ERET with same-cycle MTC0 EPC
    mem_pc_i = 32'h8000_1008; eret_i = 1; cp0_epc_i = 32'h100;
    wb_cp0_we_i = 1; wb_cp0_waddr_i = CP0_REG_EPC; wb_cp0_data_i = 32'h200;
    issue('{32'he, 32'h8000_1008, 1'b0, 32'h0, 32'h200});
    step(4);

    // AdEL on fetch in a delay slot: bad address is the PC
    mem_pc_i = 32'h8000_0101; mem_delayslot_i = 1; adel_if_i = 1; adel_d_i = 1;
    mem_addr_i = 32'h55;
    issue('{32'h4, 32'h8000_0101, 1'b1, 32'h8000_0101, VEC});
    step(4);

    // Break beats AdEL data
    mem_pc_i = 32'h8000_0200; break_i = 1; adel_d_i = 1; mem_addr_i = 32'h8000_0003;
    issue('{32'h9, 32'h8000_0200, 1'b0, 32'h0, VEC});
    step(4);

    // AdEL data in delay slot
    mem_pc_i = 32'h8000_0204; mem_delayslot_i = 1; adel_d_i = 1; mem_addr_i = 32'h8000_0003;
    issue('{32'h4, 32'h8000_0204, 1'b1, 32'h8000_0003, VEC});
    step(4);

    // AdES beats ERET
    mem_pc_i = 32'h8000_0208; ades_d_i = 1; eret_i = 1; mem_addr_i = 32'h8000_0006;
    issue('{32'h5, 32'h8000_0208, 1'b0, 32'h8000_0006, VEC});
    step(4);

    // Interrupt raised during bubbles, taken on first valid cycle
    cp0_status_i = 32'h0401; cp0_cause_i = 32'h0400;
    expect_quiet("int_bubble", 3);
    mem_pc_i = 32'h8000_2000; cp0_status_i = 32'h0401; cp0_cause_i = 32'h0400; ov_i = 1;
    issue('{32'h1, 32'h8000_2000, 1'b0, 32'h0, VEC});
    step(4);

    // EXL set masks the interrupt
    cp0_status_i = 32'h0403; cp0_cause_i = 32'h0400;
    mem_valid_i = 1; mem_pc_i = 32'h8000_2004;
    expect_quiet("int_exl", 3);
    clear_inputs();
    step(2);

    // Interrupt enabled by a same-cycle MTC0 Status
    cp0_cause_i = 32'h0400; mem_pc_i = 32'h8000_2008;
    wb_cp0_we_i = 1; wb_cp0_waddr_i = CP0_REG_STATUS; wb_cp0_data_i = 32'hFFFF_0401;
    issue('{32'h1, 32'h8000_2008, 1'b0, 32'h0, VEC});
    step(4);

    // Software interrupt raised by a same-cycle MTC0 Cause
    cp0_status_i = 32'h0101; mem_pc_i = 32'h8000_200c;
    wb_cp0_we_i = 1; wb_cp0_waddr_i = CP0_REG_CAUSE; wb_cp0_data_i = 32'h0000_0100;
    issue('{32'h1, 32'h8000_200c, 1'b0, 32'h0, VEC});
    step(4);

    // Syscall held under stall, then accepted once; repeats during FLUSH ignored
    mem_valid_i = 1; mem_stall_i = 1; syscall_i = 1; mem_pc_i = 32'h8000_3000;
    expect_quiet("stall", 2);
    mem_stall_i = 0;
    exp_q.push_back('{32'h8, 32'h8000_3000, 1'b0, 32'h0, VEC});
    step(1);
    mem_stall_i = 1;
    step(1);
    mem_stall_i = 0;
    step(1);
    clear_inputs();
    step(4);

    // Asynchronous reset in the second flush cycle
    mem_pc_i = 32'h8000_4000; break_i = 1;
    issue('{32'h9, 32'h8000_4000, 1'b0, 32'h0, VEC});
    step(1);
    rst = 0;
    #1;
    check("async_rst_flush", {31'b0, flush_o}, 32'h0);
    check("async_rst_newpc", newpc_o, 32'h0);
    check("async_rst_type", excepttype_o, 32'h0);
    step(2);
    rst = 1;
    expect_quiet("post_rst", 4);

    check("queue_empty", exp_q.size(), 32'h0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/except_unit.md
# except_unit

Memory-stage exception arbiter that drives the CP0 register block's exception inputs. It collects per-instruction exception flags and the CP0 interrupt condition, and picks one winner by fixed priority. For the one cycle CP0 samples, it presents the winner's type, PC, delay-slot flag and bad address. It then drives the pipeline flush and redirect PC, either the exception vector or EPC for ERET.

## Interface
- EXC_VECTOR, 32'hBFC00380, redirect target for every exception except ERET
- FLUSH_CYCLES, 2, cycles flush_o stays high per accepted event (legal range 1..15)
- clk  input  1  clock; all state updates on rising edge
- rst  input  1  asynchronous, active-low reset (0 = reset)
- mem_valid_i  input  1  MEM stage holds a real instruction (not a bubble)
- mem_stall_i  input  1  MEM stage frozen this cycle
- mem_pc_i  input  32  PC of the MEM instruction
- mem_delayslot_i  input  1  MEM instruction is in a branch delay slot
- mem_addr_i  input  32  data address of the MEM load/store
- adel_if_i, ri_i, ov_i, syscall_i, break_i, adel_d_i, ades_d_i, eret_i  input  1 each  per-instruction exception flags
- cp0_status_i, cp0_cause_i, cp0_epc_i  input  32 each  current CP0 register values
- wb_cp0_we_i  input  1  MTC0 in WB writes CP0 this cycle
- wb_cp0_waddr_i  input  5  MTC0 target register
- wb_cp0_data_i  input  32  MTC0 data
- excepttype_o  output  32  type code to CP0; 0 = none
- current_inst_addr_o  output  32  PC of the excepting instruction
- is_in_delayslot_o  output  1  delay-slot flag to CP0
- bad_addr_o  output  32  faulting address (AdEL/AdES only, else 0)
- flush_o  output  1  flush all stages IF..MEM
- newpc_o  output  32  redirect target; meaningful while flush_o=1

## Operation
- Effective CP0 view (forwarding from WB):
  - Status (reg 12) write: bits 15:8 and 1:0 come from wb_cp0_data_i; the rest from cp0_status_i.
  - Cause (reg 13) write: bits 9:8 come from wb_cp0_data_i.
  - EPC (reg 14) write: the whole register comes from wb_cp0_data_i.
- Interrupt condition: effStatus[0]=1, effStatus[1]=0 and (effCause[15:8] & effStatus[15:8]) != 0.
- int_pending register:
  - Set when the condition is true in IDLE.
  - Cleared when an event is accepted or when the condition becomes false.
- An interrupt is taken when int_pending or the live condition holds and the MEM stage holds an accepted instruction.
- Acceptance requires state IDLE, mem_valid_i=1 and mem_stall_i=0.
- Priority, highest first, with type codes:
  - interrupt 0x1
  - adel_if 0x4 (bad_addr = mem_pc_i)
  - ri 0xa
  - ov 0xc
  - syscall 0x8
  - break 0x9
  - adel_d 0x4 (bad_addr = mem_addr_i)
  - ades_d 0x5 (bad_addr = mem_addr_i)
  - eret 0xe
- newpc_o is effEPC for ERET and EXC_VECTOR for every other type.
- FSM:
  - IDLE: on acceptance with any winner, load the output registers, load flush_cnt=FLUSH_CYCLES, go to FLUSH.
  - FLUSH: flush_o=1; flush_cnt decrements each cycle. At flush_cnt=1, go to IDLE.
- In FLUSH, all new flags and interrupts are ignored and mem_stall_i has no effect. The count always proceeds.

## Timing
- Reset values: every output is 0, state is IDLE, int_pending=0, flush_cnt=0.
- Event sampled in cycle N. excepttype_o, current_inst_addr_o, is_in_delayslot_o and bad_addr_o are valid in cycle N+1 only, then return to 0 in N+2. CP0 captures them on the negedge inside N+1.
- flush_o is high in cycles N+1..N+FLUSH_CYCLES. newpc_o is constant over that window and returns to 0 after it.
- The earliest next acceptance is cycle N+FLUSH_CYCLES+1.
- Reset asserted mid-FLUSH: all outputs are 0 immediately (asynchronous). No residual flush after release.
- Simultaneous WB MTC0 and MEM event: the forwarded value is used in the same cycle.
- Flags present with mem_valid_i=0 or mem_stall_i=1 produce no output.

## Structure
- Shared defines header holds:
  - exception type codes 0x1/0x4/0x5/0x8/0x9/0xa/0xc/0xd/0xe
  - CP0 register numbers (STATUS=12, CAUSE=13, EPC=14)
  - ZeroWord
- Sub-module cp0_fwd: combinational merge producing effStatus/effCause/effEPC, reusable by the MFC0 bypass path.

## Test plan
- ov_i=1, mem_pc_i=0x80001000, delayslot=0 -> cycle N+1: excepttype_o=0xc, current_inst_addr_o=0x80001000; flush_o high 2 cycles; newpc_o=0xBFC00380.
- ri_i=1 and ades_d_i=1 together, mem_addr_i=0x13 -> excepttype_o=0xa, bad_addr_o=0.
- eret_i=1, cp0_epc_i=0x100, same-cycle MTC0 EPC=0x200 -> excepttype_o=0xe, newpc_o=0x200.
- Status=0x0401, cause[10]=1 set while mem_valid_i=0 for 3 cycles, then valid -> excepttype_o=0x1 on the first valid cycle +1. With Status=0x0403 (EXL=1) -> no event.
- syscall_i=1 with mem_stall_i=1 for 2 cycles then 0 -> no output until stall drops, then exactly one 0x8 pulse. A second syscall during FLUSH is ignored.
- rst low in second flush cycle -> flush_o=0 and newpc_o=0 immediately; no flush after release.
